invalidate_cpu_cache_controller: RTL
====================================

// Module: invalidate_cpu_cache_controller
// PURPOSE
//  CPU-side controller of the MSI write-invalidate snoopy cache; sits directly upstream of the set-associative cache unit.
//  Serves CPU reads/writes through hit checks, victim write-back, line fill and upgrade invalidate on the shared bus.
//  Drives the cache unit's CPU-side tag/data/state write strobes and the accessEnable pulse used by the LRU.
// PARAMETERS
//  TAG_WIDTH     8   tag bits of the CPU address
//  INDEX_WIDTH   4   set index bits
//  OFFSET_WIDTH  2   word-in-line bits; a line holds 2**OFFSET_WIDTH words
//  DATA_WIDTH    16  word width
// PORTS
//  clock                in   1            system clock
//  reset                in   1            asynchronous, active-high
//  cpuAddress           in   T+I+O        {tag, index, offset}
//  cpuRead              in   1            read request, held until complete handshake ends
//  cpuWrite             in   1            write request, held likewise
//  cpuDataIn            in   DATA_WIDTH   write data
//  cpuDataOut           out  DATA_WIDTH   read data, valid while cpuFunctionComplete=1
//  cpuFunctionComplete  out  1            access done
//  cacheIndex           out  INDEX_WIDTH  always cpuAddress index
//  cacheOffset          out  OFFSET_WIDTH cpu offset, or word counter during write-back/fill
//  cacheTag             out  TAG_WIDTH    cpu tag (compare and tag written on fill)
//  cacheDataIn          out  DATA_WIDTH   cpuDataIn on write hit, busDataIn during fill
//  cacheStateIn         out  2            state to write
//  cacheWrite           out  3            {writeTag, writeData, writeState} strobes
//  cacheHit             in   1            tag match with non-INVALID state
//  cacheTagOut          in   TAG_WIDTH    tag of selected (hit or victim) line
//  cacheDataOut         in   DATA_WIDTH   word of selected line
//  cacheStateOut        in   2            state of selected line
//  accessEnable         out  1            one-cycle pulse at completion; updates LRU
//  busRequest           out  1            bus arbitration request
//  busGrant             in   1            bus owned while high
//  busCommand           out  3            0 NONE,1 READ,2 READ_EXCLUSIVE,3 INVALIDATE,4 WRITE_BACK
//  busAddress           out  T+I+O        transaction word address
//  busDataOut           out  DATA_WIDTH   write-back word (cacheDataOut)
//  busDataIn            in   DATA_WIDTH   fill word
//  busFunctionComplete  in   1            one word / invalidate done this cycle
// BEHAVIOUR
//  States 2'b00 INVALID, 2'b01 SHARED, 2'b10 MODIFIED. FSM: IDLE, ARBITRATE, WRITE_BACK, FILL, UPGRADE, DONE.
//  Reset: FSM=IDLE, word counter 0, all outputs 0 (busCommand NONE, cacheWrite 3'b000); cache contents untouched; any bus op abandoned.
//  IDLE: read hit -> DONE next cycle, cpuDataOut registered from cacheDataOut. Write hit MODIFIED -> cacheWrite=3'b010 that cycle, DONE next.
//  Write hit SHARED, or any miss -> busRequest=1, ARBITRATE. cpuRead and cpuWrite both high: read wins.
//  ARBITRATE: wait for busGrant; on grant re-evaluate hit/state (snoop may have invalidated line):
//   still SHARED hit on write -> UPGRADE; miss with victim MODIFIED -> WRITE_BACK; other miss -> FILL.
//  WRITE_BACK: busCommand=4, busAddress={cacheTagOut,index,counter}; counter++ on each busFunctionComplete; after last word counter=0, FILL.
//  FILL: busCommand=1 (read) or 2 (write); each busFunctionComplete writes busDataIn at counter (cacheWrite data bit);
//   last word also writes tag and state (SHARED for read, MODIFIED for write); drop busRequest, return IDLE, access re-evaluated as hit.
//  UPGRADE: busCommand=3 until busFunctionComplete; then cacheWrite=3'b011, data=cpuDataIn, state MODIFIED; drop busRequest, DONE.
//  DONE: cpuFunctionComplete=1, accessEnable=1 first cycle only; stay until cpuRead=cpuWrite=0, then IDLE. Counter wraps 2**O-1 -> 0.
//  Loss of busGrant mid-transaction is illegal. cpuRead/cpuWrite dropped before DONE: op completes on the bus, then DONE exits immediately.
// TESTING
//  Reset, read miss to empty set, addr 0x1234 -> READ 4 words, line SHARED, cpuDataOut=word0 fill data, accessEnable single pulse.
//  Write hit on SHARED line -> one INVALIDATE, state MODIFIED, data=0xBEEF, no read traffic.
//  Miss with MODIFIED victim -> 4 WRITE_BACK words at victim tag addresses in order 0..3, then READ_EXCLUSIVE fill.
//  Snoop invalidates SHARED line while in ARBITRATE for upgrade -> READ_EXCLUSIVE fill instead of INVALIDATE.
//  Reset asserted mid-FILL (word 2) -> next cycle IDLE, busRequest=0, busCommand=NONE; next access restarts cleanly.

Source files
------------

// File: rtl/invalidate_cpu_cache_controller.sv
// CPU-side MSI write-invalidate controller: hit checks, victim write-back, line fill, upgrade invalidate.
// Latency: read hit / modified write hit complete one cycle after the request; misses add arbitration plus bus words.
// Backpressure: the CPU request is held until cpuFunctionComplete; bus progress is paced by busGrant/busFunctionComplete.
module invalidate_cpu_cache_controller #(
    parameter int TAG_WIDTH    = 8,
    parameter int INDEX_WIDTH  = 4,
    parameter int OFFSET_WIDTH = 2,
    parameter int DATA_WIDTH   = 16
) (
    input  logic                                            clock,
    input  logic                                            reset,
    input  logic [TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1:0]   cpuAddress,
    input  logic                                            cpuRead,
    input  logic                                            cpuWrite,
    input  logic [DATA_WIDTH-1:0]                           cpuDataIn,
    output logic [DATA_WIDTH-1:0]                           cpuDataOut,
    output logic                                            cpuFunctionComplete,
    output logic [INDEX_WIDTH-1:0]                          cacheIndex,
    output logic [OFFSET_WIDTH-1:0]                         cacheOffset,
    output logic [TAG_WIDTH-1:0]                            cacheTag,
    output logic [DATA_WIDTH-1:0]                           cacheDataIn,
    output logic [1:0]                                      cacheStateIn,
    output logic [2:0]                                      cacheWrite,
    input  logic                                            cacheHit,
    input  logic [TAG_WIDTH-1:0]                            cacheTagOut,
    input  logic [DATA_WIDTH-1:0]                           cacheDataOut,
    input  logic [1:0]                                      cacheStateOut,
    output logic                                            accessEnable,
    output logic                                            busRequest,
    output logic [2:0]                                      busCommand,
    output logic [TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1:0]   busAddress,
    output logic [DATA_WIDTH-1:0]                           busDataOut,
    input  logic                                            busGrant,
    input  logic [DATA_WIDTH-1:0]                           busDataIn,
    input  logic                                            busFunctionComplete
);

    localparam logic [1:0] ST_INVALID  = 2'b00;
    localparam logic [1:0] ST_SHARED   = 2'b01;
    localparam logic [1:0] ST_MODIFIED = 2'b10;

    localparam logic [2:0] CMD_NONE       = 3'd0;
    localparam logic [2:0] CMD_READ       = 3'd1;
    localparam logic [2:0] CMD_READ_EXCL  = 3'd2;
    localparam logic [2:0] CMD_INVALIDATE = 3'd3;
    localparam logic [2:0] CMD_WRITE_BACK = 3'd4;

    localparam logic [OFFSET_WIDTH-1:0] LAST_WORD = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_ARBITRATE, S_WRITE_BACK, S_FILL, S_UPGRADE, S_DONE
    } state_t;

    state_t                  state_q;
    logic [OFFSET_WIDTH-1:0] cnt_q;
    logic                    op_wr_q;
    logic                    busRequest_q;
    logic [2:0]              busCommand_q;
    logic [DATA_WIDTH-1:0]   cpuDataOut_q;
    logic                    cpuFunctionComplete_q;
    logic                    accessEnable_q;

    logic [TAG_WIDTH-1:0]    cpu_tag;
    logic [INDEX_WIDTH-1:0]  cpu_idx;
    logic [OFFSET_WIDTH-1:0] cpu_off;
    logic                    req_any;
    logic                    req_wr;
    logic                    hit_shared;
    logic                    victim_dirty;
    logic                    last_word;
    logic [2:0]              fill_cmd;

    assign cpu_tag      = cpuAddress[TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1 -: TAG_WIDTH];
    assign cpu_idx      = cpuAddress[OFFSET_WIDTH +: INDEX_WIDTH];
    assign cpu_off      = cpuAddress[OFFSET_WIDTH-1:0];
    // Read wins when both request lines are high.
    assign req_any      = cpuRead | cpuWrite;
    assign req_wr       = cpuWrite & ~cpuRead;
    assign hit_shared   = cacheHit && (cacheStateOut == ST_SHARED);
    // On a miss the cache unit presents the victim line, so its state tells us whether it is dirty.
    assign victim_dirty = !cacheHit && (cacheStateOut == ST_MODIFIED);
    assign last_word    = (cnt_q == LAST_WORD);
    assign fill_cmd     = op_wr_q ? CMD_READ_EXCL : CMD_READ;

    assign cpuDataOut          = cpuDataOut_q;
    assign cpuFunctionComplete = cpuFunctionComplete_q;
    assign accessEnable        = accessEnable_q;
    assign busRequest          = busRequest_q;
    assign busCommand          = busCommand_q;
    assign cacheIndex          = cpu_idx;
    assign cacheTag            = cpu_tag;
    assign cacheOffset         = (state_q == S_WRITE_BACK || state_q == S_FILL) ? cnt_q : cpu_off;
    assign busDataOut          = (state_q == S_WRITE_BACK) ? cacheDataOut : '0;

    // Bus address: victim tag during write-back, requested line during fill, CPU word for invalidate.
    always_comb begin
        busAddress = '0;
        case (state_q)
            S_WRITE_BACK: busAddress = {cacheTagOut, cpu_idx, cnt_q};
            S_FILL:       busAddress = {cpu_tag, cpu_idx, cnt_q};
            S_UPGRADE:    busAddress = cpuAddress;
            default:      busAddress = '0;
        endcase
    end

    // Cache-unit write strobes are issued in the same cycle as the hit or bus word that produces them.
    always_comb begin
        cacheWrite   = 3'b000;
        cacheDataIn  = '0;
        cacheStateIn = ST_INVALID;
        case (state_q)
            S_IDLE: begin
                if (req_wr && cacheHit && (cacheStateOut == ST_MODIFIED)) begin
                    cacheWrite  = 3'b010;
                    cacheDataIn = cpuDataIn;
                end
            end
            S_FILL: begin
                if (busFunctionComplete) begin
                    cacheWrite  = last_word ? 3'b111 : 3'b010;
                    cacheDataIn = busDataIn;
                    if (last_word) begin
                        cacheStateIn = op_wr_q ? ST_MODIFIED : ST_SHARED;
                    end
                end
            end
            S_UPGRADE: begin
                if (busFunctionComplete) begin
                    cacheWrite   = 3'b011;
                    cacheDataIn  = cpuDataIn;
                    cacheStateIn = ST_MODIFIED;
                end
            end
            default: ;
        endcase
        if (reset) begin
            cacheWrite   = 3'b000;
            cacheDataIn  = '0;
            cacheStateIn = ST_INVALID;
        end
    end

    // Control FSM with registered CPU-side and bus-side outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q               <= S_IDLE;
            cnt_q                 <= '0;
            op_wr_q               <= 1'b0;
            busRequest_q          <= 1'b0;
            busCommand_q          <= CMD_NONE;
            cpuDataOut_q          <= '0;
            cpuFunctionComplete_q <= 1'b0;
            accessEnable_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_any) begin
                        if (cacheHit && (cpuRead || cacheStateOut == ST_MODIFIED)) begin
                            if (cpuRead) begin
                                cpuDataOut_q <= cacheDataOut;
                            end
                            cpuFunctionComplete_q <= 1'b1;
                            accessEnable_q        <= 1'b1;
                            state_q               <= S_DONE;
                        end else begin
                            busRequest_q <= 1'b1;
                            op_wr_q      <= req_wr;
                            state_q      <= S_ARBITRATE;
                        end
                    end
                end
                S_ARBITRATE: begin
                    // A snoop may have invalidated the line while waiting, so hit/state are re-checked here.
                    if (busGrant) begin
                        cnt_q <= '0;
                        if (op_wr_q && hit_shared) begin
                            busCommand_q <= CMD_INVALIDATE;
                            state_q      <= S_UPGRADE;
                        end else if (victim_dirty) begin
                            busCommand_q <= CMD_WRITE_BACK;
                            state_q      <= S_WRITE_BACK;
                        end else begin
                            busCommand_q <= fill_cmd;
                            state_q      <= S_FILL;
                        end
                    end
                end
                S_WRITE_BACK: begin
                    if (busFunctionComplete) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (last_word) begin
                            busCommand_q <= fill_cmd;
                            state_q      <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    // After the last word the access is replayed from IDLE, where it now hits.
                    if (busFunctionComplete) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (last_word) begin
                            busRequest_q <= 1'b0;
                            busCommand_q <= CMD_NONE;
                            state_q      <= S_IDLE;
                        end
                    end
                end
                S_UPGRADE: begin
                    if (busFunctionComplete) begin
                        busRequest_q          <= 1'b0;
                        busCommand_q          <= CMD_NONE;
                        cpuFunctionComplete_q <= 1'b1;
                        accessEnable_q        <= 1'b1;
                        state_q               <= S_DONE;
                    end
                end
                S_DONE: begin
                    accessEnable_q <= 1'b0;
                    if (!req_any) begin
                        cpuFunctionComplete_q <= 1'b0;
                        state_q               <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
